// File: rtl/mem_access_ctrl.sv
// Single-port RAM access sequencer arbitrating IF (read-only) and MEM (read/write) with fixed latency.
// Optional statistics counters enabled by defining MEM_ACCESS_STATS_EN.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        freeze,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [31:0] stall_cnt,
  output logic [31:0] access_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                grant_mem_q;
  logic                last_mem_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic                if_ready_q;
  logic                mem_ready_q;
  logic                ram_en_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;

  logic mem_pend;
  logic pick_mem;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    mem_pend = MEM_R_EN | MEM_W_EN;
    pick_mem = mem_pend & (~if_req | ~last_mem_q);
  end

  // Sequencer: grant in IDLE, hold RAM controls through ACCESS, pulse ready in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_mem_q <= 1'b0;
      last_mem_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (if_req || mem_pend) begin
            grant_mem_q <= pick_mem;
            ram_addr_q  <= pick_mem ? mem_addr : if_addr;
            ram_we_q    <= pick_mem & MEM_W_EN;
            if (pick_mem) begin
              ram_wdata_q <= mem_wdata;
            end
            ram_en_q    <= 1'b1;
            cnt_q       <= CNT_W'(WAIT_CYCLES - 1);
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            if (!grant_mem_q) begin
              if_rdata_q <= ram_rdata;
            end else if (!ram_we_q) begin
              mem_rdata_q <= ram_rdata;
            end
            last_mem_q  <= grant_mem_q;
            if_ready_q  <= ~grant_mem_q;
            mem_ready_q <= grant_mem_q;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // A requester stalls the pipeline until its own ready pulse.
  assign freeze = (if_req & ~if_ready_q) | (mem_pend & ~mem_ready_q);

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] access_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      access_cnt_q <= '0;
    end else begin
      if (freeze) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (if_ready_q || mem_ready_q) begin
        access_cnt_q <= access_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign access_cnt = access_cnt_q;
`else
  assign stall_cnt  = '0;
  assign access_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 4 and 1) checked every cycle against a timestamp model.
module tb_mem_access_ctrl;

  localparam int NI = 2;

  logic        clk;
  logic        rst;
  logic        if_req     [NI];
  logic [31:0] if_addr    [NI];
  logic [31:0] if_rdata   [NI];
  logic        if_ready   [NI];
  logic        mem_r_en   [NI];
  logic        mem_w_en   [NI];
  logic [31:0] mem_addr   [NI];
  logic [31:0] mem_wdata  [NI];
  logic [31:0] mem_rdata  [NI];
  logic        mem_ready  [NI];
  logic        freeze     [NI];
  logic        ram_en     [NI];
  logic        ram_we     [NI];
  logic [31:0] ram_addr   [NI];
  logic [31:0] ram_wdata  [NI];
  logic [31:0] ram_rdata  [NI];
  logic [31:0] stall_cnt  [NI];
  logic [31:0] access_cnt [NI];

  int n_chk;
  int n_pass;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_CYCLES(4), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
    .MEM_R_EN(mem_r_en[0]), .MEM_W_EN(mem_w_en[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]), .freeze(freeze[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0]), .stall_cnt(stall_cnt[0]), .access_cnt(access_cnt[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
    .MEM_R_EN(mem_r_en[1]), .MEM_W_EN(mem_w_en[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]), .freeze(freeze[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1]), .stall_cnt(stall_cnt[1]), .access_cnt(access_cnt[1])
  );

  // RAM contents as a pure function of address; 0x100 holds a known instruction word.
  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h8C22_0004;
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign ram_rdata[0] = ram_fn(ram_addr[0]);
  assign ram_rdata[1] = ram_fn(ram_addr[1]);

  function automatic int wc(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: an access granted at cycle g occupies the RAM in g+1..g+W and reports ready at g+W+1.
  bit          m_active  [NI];
  int          m_gcyc    [NI];
  bit          m_gmem    [NI];
  bit          m_lastmem [NI];
  logic [31:0] m_addr    [NI];
  logic [31:0] m_wdata   [NI];
  bit          m_we      [NI];
  logic [31:0] m_if      [NI];
  logic [31:0] m_mem     [NI];
  logic [31:0] m_stall   [NI];
  logic [31:0] m_acc     [NI];

  always @(negedge clk) begin
    int d;
    int w;
    bit busy, e_en, e_ifr, e_mr, e_fz, mp, pm;
    cyc = cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        m_active[k]  = 1'b0;
        m_lastmem[k] = 1'b0;
        m_if[k]      = '0;
        m_mem[k]     = '0;
        m_stall[k]   = '0;
        m_acc[k]     = '0;
        chk($sformatf("u%0d.rst_ram_en", k), 32'(ram_en[k]), 32'd0);
        chk($sformatf("u%0d.rst_ram_we", k), 32'(ram_we[k]), 32'd0);
        chk($sformatf("u%0d.rst_ready", k), 32'({if_ready[k], mem_ready[k]}), 32'd0);
        chk($sformatf("u%0d.rst_ram_addr", k), ram_addr[k], 32'd0);
        chk($sformatf("u%0d.rst_rdata", k), if_rdata[k] | mem_rdata[k], 32'd0);
        chk($sformatf("u%0d.rst_stats", k), stall_cnt[k] | access_cnt[k], 32'd0);
      end else begin
        w     = wc(k);
        d     = cyc - m_gcyc[k];
        busy  = m_active[k] && (d <= w + 1);
        e_en  = m_active[k] && (d >= 1) && (d <= w);
        e_ifr = m_active[k] && (d == w + 1) && !m_gmem[k];
        e_mr  = m_active[k] && (d == w + 1) && m_gmem[k];
        if (e_ifr) m_if[k] = ram_fn(m_addr[k]);
        if (e_mr && !m_we[k]) m_mem[k] = ram_fn(m_addr[k]);
        mp   = mem_r_en[k] | mem_w_en[k];
        e_fz = (if_req[k] & ~e_ifr) | (mp & ~e_mr);
        chk($sformatf("u%0d.ram_en", k), 32'(ram_en[k]), 32'(e_en));
        chk($sformatf("u%0d.if_ready", k), 32'(if_ready[k]), 32'(e_ifr));
        chk($sformatf("u%0d.mem_ready", k), 32'(mem_ready[k]), 32'(e_mr));
        chk($sformatf("u%0d.if_rdata", k), if_rdata[k], m_if[k]);
        chk($sformatf("u%0d.mem_rdata", k), mem_rdata[k], m_mem[k]);
        chk($sformatf("u%0d.freeze", k), 32'(freeze[k]), 32'(e_fz));
        if (e_en) begin
          chk($sformatf("u%0d.ram_we", k), 32'(ram_we[k]), 32'(m_we[k]));
          chk($sformatf("u%0d.ram_addr", k), ram_addr[k], m_addr[k]);
          if (m_we[k]) chk($sformatf("u%0d.ram_wdata", k), ram_wdata[k], m_wdata[k]);
        end
`ifdef MEM_ACCESS_STATS_EN
        chk($sformatf("u%0d.stall_cnt", k), stall_cnt[k], m_stall[k]);
        chk($sformatf("u%0d.access_cnt", k), access_cnt[k], m_acc[k]);
`else
        chk($sformatf("u%0d.stats_off", k), stall_cnt[k] | access_cnt[k], 32'd0);
`endif
        if (e_fz) m_stall[k] = m_stall[k] + 32'd1;
        if (e_ifr || e_mr) m_acc[k] = m_acc[k] + 32'd1;
        if (!busy && (if_req[k] || mp)) begin
          pm           = mp && (!if_req[k] || !m_lastmem[k]);
          m_active[k]  = 1'b1;
          m_gcyc[k]    = cyc;
          m_gmem[k]    = pm;
          m_lastmem[k] = pm;
          m_addr[k]    = pm ? mem_addr[k] : if_addr[k];
          m_we[k]      = pm && mem_w_en[k];
          m_wdata[k]   = mem_wdata[k];
        end
      end
    end
  end

  task automatic new_mem_op(input int k);
    int op;
    op           = int'($urandom_range(0, 3));
    mem_r_en[k]  = (op != 1);
    mem_w_en[k]  = (op == 1) || (op == 2);
    mem_addr[k]  = $urandom;
    mem_wdata[k] = $urandom;
  endtask

  task automatic rand_drive(input int k);
    if (if_req[k]) begin
      if (if_ready[k]) begin
        if ($urandom_range(0, 3) == 0) if_addr[k] = $urandom;
        else if_req[k] = 1'b0;
      end else if ($urandom_range(0, 63) == 0) begin
        if_req[k] = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req[k]  = 1'b1;
      if_addr[k] = $urandom;
    end
    if (mem_r_en[k] || mem_w_en[k]) begin
      if (mem_ready[k]) begin
        if ($urandom_range(0, 3) == 0) new_mem_op(k);
        else begin
          mem_r_en[k] = 1'b0;
          mem_w_en[k] = 1'b0;
        end
      end else if ($urandom_range(0, 63) == 0) begin
        mem_r_en[k] = 1'b0;
        mem_w_en[k] = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      new_mem_op(k);
    end
  endtask

  initial begin
    int mr, ir, fz, en, got;
    int seq [6];
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    for (int k = 0; k < NI; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; mem_r_en[k] = 1'b0; mem_w_en[k] = 1'b0;
      mem_addr[k] = '0; mem_wdata[k] = '0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();
    step();
    chk("init_if_rdata", if_rdata[0], 32'd0);
    chk("init_freeze", 32'(freeze[0]), 32'd0);
    chk("init_stall_cnt", stall_cnt[0], 32'd0);

    // Simultaneous IF read 0x0 and MEM read 0x80 right after reset.
    if_req[0] = 1'b1; if_addr[0] = 32'h0; mem_r_en[0] = 1'b1; mem_addr[0] = 32'h80;
    mr = -1; ir = -1; fz = 0;
    #1;
    if (freeze[0]) fz = fz + 1;
    for (int n = 1; n <= 13; n++) begin
      step();
      if (freeze[0]) fz = fz + 1;
      if (n == 11) chk("A_freeze_c11", 32'(freeze[0]), 32'd0);
      if (n == 12) begin
`ifdef MEM_ACCESS_STATS_EN
        chk("A_stall_cnt", stall_cnt[0], 32'd11);
        chk("A_access_cnt", access_cnt[0], 32'd2);
`else
        chk("A_stall_cnt", stall_cnt[0], 32'd0);
        chk("A_access_cnt", access_cnt[0], 32'd0);
`endif
      end
      if (mem_ready[0]) begin
        if (mr < 0) mr = n;
        mem_r_en[0] = 1'b0;
      end
      if (if_ready[0]) begin
        if (ir < 0) ir = n;
        if_req[0] = 1'b0;
      end
    end
    chk("A_mem_ready_cyc", 32'(mr), 32'd5);
    chk("A_if_ready_cyc", 32'(ir), 32'd11);
    chk("A_freeze_cycles", 32'(fz), 32'd11);

    // IF read of 0x100.
    step();
    if_req[0] = 1'b1; if_addr[0] = 32'h100; ir = -1;
    #1;
    chk("B_freeze_c0", 32'(freeze[0]), 32'd1);
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("B_freeze_c%0d", n), 32'(freeze[0]), 32'(n < 5));
      if (if_ready[0]) begin
        ir = n;
        chk("B_if_rdata", if_rdata[0], 32'h8C22_0004);
        if_req[0] = 1'b0;
      end
    end
    chk("B_if_ready_cyc", 32'(ir), 32'd5);

    // MEM write, then a second write cut short by reset.
    step();
    mem_w_en[0] = 1'b1; mem_addr[0] = 32'h40; mem_wdata[0] = 32'hDEAD_BEEF;
    en = 0; mr = -1;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("C_ram_en_c%0d", n), 32'(ram_en[0]), 32'(n <= 4));
      if (n == 1) begin
        chk("C_ram_addr", ram_addr[0], 32'h40);
        chk("C_ram_wdata", ram_wdata[0], 32'hDEAD_BEEF);
      end
      if (ram_en[0] && ram_we[0]) en = en + 1;
      if (mem_ready[0]) begin
        mr = n;
        mem_w_en[0] = 1'b0;
      end
    end
    chk("C_we_cycles", 32'(en), 32'd4);
    chk("C_mem_ready_cyc", 32'(mr), 32'd5);
    step();
    mem_w_en[0] = 1'b1; mem_addr[0] = 32'h44; mem_wdata[0] = 32'h0BAD_F00D;
    step();
    step();
    chk("C2_ram_en_c2", 32'(ram_en[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("C2_ram_en_rst", 32'(ram_en[0]), 32'd0);
    chk("C2_ram_we_rst", 32'(ram_we[0]), 32'd0);
    chk("C2_ram_addr_rst", ram_addr[0], 32'd0);
    chk("C2_ram_wdata_rst", ram_wdata[0], 32'd0);
    chk("C2_if_rdata_rst", if_rdata[0], 32'd0);
    mem_w_en[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();

    // Both requesters held high: grants must alternate starting with MEM.
    if_req[0] = 1'b1; if_addr[0] = 32'h200; mem_r_en[0] = 1'b1; mem_addr[0] = 32'h300;
    got = 0;
    for (int n = 1; n <= 200 && got < 6; n++) begin
      step();
      if (mem_ready[0]) begin
        seq[got] = 1;
        got = got + 1;
      end else if (if_ready[0]) begin
        seq[got] = 0;
        got = got + 1;
      end
    end
    if_req[0] = 1'b0; mem_r_en[0] = 1'b0;
    chk("D_events", 32'(got), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got) chk($sformatf("D_grant%0d", i), 32'(seq[i]), 32'((i % 2) == 0));
    end

    // WAIT_CYCLES=1: a read, then a read+write collision that must behave as a write.
    step();
    mem_r_en[1] = 1'b1; mem_addr[1] = 32'h500; mr = -1;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (mem_ready[1]) begin
        if (mr < 0) mr = n;
        mem_r_en[1] = 1'b0;
      end
    end
    chk("E_read_ready_cyc", 32'(mr), 32'd2);
    chk("E_read_rdata", mem_rdata[1], 32'h1734_A987);
    step();
    mem_r_en[1] = 1'b1; mem_w_en[1] = 1'b1; mem_addr[1] = 32'h504; mem_wdata[1] = 32'hCAFE_F00D;
    en = 0; mr = -1;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (ram_en[1]) begin
        en = en + 1;
        chk("E_ram_we", 32'(ram_we[1]), 32'd1);
      end
      if (mem_ready[1]) begin
        if (mr < 0) mr = n;
        mem_r_en[1] = 1'b0;
        mem_w_en[1] = 1'b0;
      end
    end
    chk("E_access_cycles", 32'(en), 32'd1);
    chk("E_rw_ready_cyc", 32'(mr), 32'd2);
    chk("E_rdata_kept", mem_rdata[1], 32'h1734_A987);

    // Randomized traffic on both instances.
    repeat (4000) begin
      step();
      rand_drive(0);
      rand_drive(1);
    end
    for (int k = 0; k < NI; k++) begin
      if_req[k] = 1'b0; mem_r_en[k] = 1'b0; mem_w_en[k] = 1'b0;
    end
    repeat (8) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
